// File: rtl/wb_writeback_unit.sv
// Writeback stage: owns the register-file write port, waits on load responses and formats load data.
// Optional load timeout is compiled in with `define WB_TIMEOUT_EN.
module wb_writeback_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic        mem_mem_to_reg,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic [1:0]  mem_load_mode,
  input  logic [1:0]  mem_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        RegWrite,
  output logic [5:0]  write_register,
  output logic [31:0] write_data,
  output logic [1:0]  load_mode,
  output logic        align_err,
  output logic        load_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_WAIT_MEM = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        we_q, we_d;
  logic [5:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        align_err_q, align_err_d;
  logic        accept_s;
  logic        misaligned_s;

  function automatic logic [31:0] format_load(input logic [31:0] d, input logic [1:0] mode,
                                               input logic [1:0] lo);
    logic [15:0] h;
    logic [7:0]  b;
    h = lo[1] ? d[31:16] : d[15:0];
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = d[7:0];
    endcase
    case (mode)
      2'b00:   format_load = d;
      2'b01:   format_load = {16'h0000, h};
      2'b10:   format_load = {{16{h[15]}}, h};
      2'b11:   format_load = {{24{b[7]}}, b};
      default: format_load = d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] lo);
    case (mode)
      2'b00:        is_misaligned = (lo != 2'b00);
      2'b01, 2'b10: is_misaligned = lo[0];
      default:      is_misaligned = 1'b0;
    endcase
  endfunction

  assign stall        = (state_q == S_WAIT_MEM);
  assign accept_s     = mem_valid && !stall;
  assign misaligned_s = mem_mem_to_reg && is_misaligned(mem_load_mode, mem_addr_lo);

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_err_q, load_err_d;
  assign load_err = load_err_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT == 32'd0);
  assign load_err         = 1'b0;
`endif

  // Next-state and registered write-port values.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mode_d      = mode_q;
    addr_lo_d   = addr_lo_q;
    we_d        = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    align_err_d = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d       = cnt_q;
    load_err_d  = load_err_q;
`endif
    case (state_q)
      S_IDLE, S_COMMIT: begin
        if (accept_s && mem_mem_to_reg && !misaligned_s) begin
          state_d     = S_WAIT_MEM;
          rd_d        = mem_rd;
          reg_write_d = mem_reg_write;
          mode_d      = mem_load_mode;
          addr_lo_d   = mem_addr_lo;
`ifdef WB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (accept_s) begin
          // Misaligned loads take the commit slot but never write.
          state_d     = S_COMMIT;
          we_d        = mem_reg_write && (mem_rd != 5'd0) && !misaligned_s;
          wreg_d      = {1'b0, mem_rd};
          wdata_d     = misaligned_s ? wdata_q : mem_alu_result;
          align_err_d = misaligned_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        if (dmem_rvalid) begin
          state_d = S_COMMIT;
          we_d    = reg_write_q && (rd_q != 5'd0);
          wreg_d  = {1'b0, rd_q};
          wdata_d = format_load(dmem_rdata, mode_q, addr_lo_q);
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = S_IDLE;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`else
        else begin
          state_d = S_WAIT_MEM;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched load context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      mode_q      <= 2'b00;
      addr_lo_q   <= 2'b00;
      we_q        <= 1'b0;
      wreg_q      <= 6'd0;
      wdata_q     <= 32'd0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mode_q      <= mode_d;
      addr_lo_q   <= addr_lo_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      align_err_q <= align_err_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end
`endif

  assign RegWrite       = we_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign align_err      = align_err_q;
  assign load_mode      = 2'b00;

endmodule
